score_note_buffer: RTL

- Write side of the score display path: captures decoded note events (note, duration, note_dec) and stores them in a 4-line x 16-slot note memory in arrival order.
- The pixel renderer reads the memory by (score line, slot) with a fixed 2-cycle latency, matching its 2-stage video pipeline.
- Owns the write cursor and page-full handling: a full page is cleared automatically before the next note is placed.

---
 rtl/score_note_buffer_if.sv | 41 ++++
 rtl/score_note_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/score_note_buffer_if.sv
// Interface bundling the note-capture, cursor/status and renderer read signals
// of the score note buffer. The design drives the slave side; the producer
// and renderer side drives the master side.
interface score_note_buffer_if #(
    parameter int NUM_SCORES      = 4,
    parameter int SLOTS_PER_SCORE = 16,
    parameter int NOTE_W          = 8,
    parameter int DUR_W           = 4
);
    localparam int SC_W = $clog2(NUM_SCORES);
    localparam int SL_W = $clog2(SLOTS_PER_SCORE);

    // Write side: decoded note events and page erase request
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              note_dec;
    logic              clear_req;

    // Renderer read port
    logic [SC_W-1:0]   rd_score;
    logic [SL_W-1:0]   rd_slot;
    logic              rd_valid;
    logic [NOTE_W-1:0] rd_note;
    logic [DUR_W-1:0]  rd_duration;

    // Cursor and status
    logic [SC_W-1:0]   wr_score;
    logic [SL_W-1:0]   wr_slot;
    logic              busy;
    logic              dropped;

    modport master (
        output note, duration, note_dec, clear_req, rd_score, rd_slot,
        input  rd_valid, rd_note, rd_duration, wr_score, wr_slot, busy, dropped
    );

    modport slave (
        input  note, duration, note_dec, clear_req, rd_score, rd_slot,
        output rd_valid, rd_note, rd_duration, wr_score, wr_slot, busy, dropped
    );
endinterface

// File: rtl/score_note_buffer.sv
// Score note buffer: stores decoded notes in arrival order into a
// NUM_SCORES x SLOTS_PER_SCORE memory, clears a full page before placing the
// next note, and serves the pixel renderer with a fixed 2-cycle read latency.
module score_note_buffer #(
    parameter int NUM_SCORES      = 4,
    parameter int SLOTS_PER_SCORE = 16,
    parameter int NOTE_W          = 8,
    parameter int DUR_W           = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    score_note_buffer_if.slave   bus
);
    localparam int SC_W  = $clog2(NUM_SCORES);
    localparam int SL_W  = $clog2(SLOTS_PER_SCORE);
    localparam int AW    = SC_W + SL_W;
    localparam int DEPTH = NUM_SCORES * SLOTS_PER_SCORE;
    localparam int EW    = 1 + NOTE_W + DUR_W;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    // Both sizes are powers of two, so {score, slot} is a linear address and
    // the cursor advances as a single counter that wraps slot into score.
    logic [AW-1:0]     cursor_reg, cursor_next;
    logic [AW-1:0]     clr_idx_reg, clr_idx_next;
    logic              page_full_reg, page_full_next;
    logic              pend_vld_reg, pend_vld_next;
    logic [NOTE_W-1:0] pend_note_reg, pend_note_next;
    logic [DUR_W-1:0]  pend_dur_reg, pend_dur_next;
    logic              dropped_reg, dropped_next;

    logic              we;
    logic [AW-1:0]     waddr;
    logic [EW-1:0]     wdata;

    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     rdata_reg;
    logic              busy_s1_reg;
    logic              rd_valid_reg;
    logic [NOTE_W-1:0] rd_note_reg;
    logic [DUR_W-1:0]  rd_dur_reg;

    logic              busy;
    logic [AW-1:0]     raddr;

    assign busy  = (state_reg == CLEAR);
    assign raddr = {bus.rd_score, bus.rd_slot};

    // Control state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= CLEAR;
            cursor_reg    <= '0;
            clr_idx_reg   <= '0;
            page_full_reg <= 1'b0;
            pend_vld_reg  <= 1'b0;
            pend_note_reg <= '0;
            pend_dur_reg  <= '0;
            dropped_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cursor_reg    <= cursor_next;
            clr_idx_reg   <= clr_idx_next;
            page_full_reg <= page_full_next;
            pend_vld_reg  <= pend_vld_next;
            pend_note_reg <= pend_note_next;
            pend_dur_reg  <= pend_dur_next;
            dropped_reg   <= dropped_next;
        end
    end

    // Next-state, cursor handling and memory write request
    always_comb begin
        state_next     = state_reg;
        cursor_next    = cursor_reg;
        clr_idx_next   = clr_idx_reg;
        page_full_next = page_full_reg;
        pend_vld_next  = pend_vld_reg;
        pend_note_next = pend_note_reg;
        pend_dur_next  = pend_dur_reg;
        dropped_next   = 1'b0;
        we             = 1'b0;
        waddr          = cursor_reg;
        wdata          = '0;

        case (state_reg)
            CLEAR: begin
                // One entry per cycle; events arriving now are lost.
                we           = 1'b1;
                waddr        = clr_idx_reg;
                wdata        = '0;
                dropped_next = bus.note_dec;
                clr_idx_next = clr_idx_reg + AW'(1);
                if (clr_idx_reg == {AW{1'b1}}) begin
                    state_next = pend_vld_reg ? PEND : IDLE;
                end
            end

            PEND: begin
                // The note that overflowed the old page opens the new one.
                we             = 1'b1;
                waddr          = '0;
                wdata          = {1'b1, pend_note_reg, pend_dur_reg};
                cursor_next    = AW'(1);
                page_full_next = 1'b0;
                pend_vld_next  = 1'b0;
                dropped_next   = bus.note_dec;
                state_next     = IDLE;
            end

            IDLE: begin
                if (bus.clear_req) begin
                    state_next     = CLEAR;
                    clr_idx_next   = '0;
                    cursor_next    = '0;
                    page_full_next = 1'b0;
                    dropped_next   = bus.note_dec;
                end else if (bus.note_dec && (bus.duration != '0)) begin
                    if (page_full_reg) begin
                        pend_vld_next  = 1'b1;
                        pend_note_next = bus.note;
                        pend_dur_next  = bus.duration;
                        clr_idx_next   = '0;
                        state_next     = CLEAR;
                    end else begin
                        we          = 1'b1;
                        waddr       = cursor_reg;
                        wdata       = {1'b1, bus.note, bus.duration};
                        cursor_next = cursor_reg + AW'(1);
                        if (cursor_reg == {AW{1'b1}}) begin
                            page_full_next = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Note memory: one write port, registered read-before-write read port
    always_ff @(posedge clk) begin
        if (we && reset) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    // Read output stage; reads launched during a clear report empty slots
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_s1_reg  <= 1'b1;
            rd_valid_reg <= 1'b0;
            rd_note_reg  <= '0;
            rd_dur_reg   <= '0;
        end else begin
            busy_s1_reg  <= busy;
            rd_valid_reg <= rdata_reg[EW-1] & ~busy_s1_reg;
            rd_note_reg  <= rdata_reg[DUR_W +: NOTE_W];
            rd_dur_reg   <= rdata_reg[DUR_W-1:0];
        end
    end

    assign bus.rd_valid    = rd_valid_reg;
    assign bus.rd_note     = rd_note_reg;
    assign bus.rd_duration = rd_dur_reg;
    assign bus.wr_score    = cursor_reg[AW-1:SL_W];
    assign bus.wr_slot     = cursor_reg[SL_W-1:0];
    assign bus.busy        = busy;
    assign bus.dropped     = dropped_reg;
endmodule
